// File: rtl/result_normalizer_if.sv
// Handshake/data bundle between the upstream datapath, result_normalizer and
// the result_rounder path. slave = normalizer side, master = driver side.
interface result_normalizer_if #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3
);
  localparam int W  = MANTISSA_WIDTH + ROUNDING_BITS + 2;
  localparam int EW = EXPONENT_WIDTH + 2;

  logic                      in_valid;
  logic                      in_ready;
  logic [EW-1:0]             in_exponent;
  logic [W-1:0]              in_mantissa;
  logic                      out_valid;
  logic                      out_ready;
  logic [EXPONENT_WIDTH-1:0] out_exponent;
  logic [MANTISSA_WIDTH-1:0] out_mantissa;
  logic [ROUNDING_BITS-1:0]  out_rounding_bits;
  logic                      overflow_flag;
  logic                      underflow_flag;

  modport slave (
    input  in_valid, in_exponent, in_mantissa, out_ready,
    output in_ready, out_valid, out_exponent, out_mantissa, out_rounding_bits,
           overflow_flag, underflow_flag
  );

  modport master (
    output in_valid, in_exponent, in_mantissa, out_ready,
    input  in_ready, out_valid, out_exponent, out_mantissa, out_rounding_bits,
           overflow_flag, underflow_flag
  );
endinterface

// File: rtl/result_normalizer.sv
// result_normalizer: bit-serial normalizer feeding result_rounder.
// One shift per cycle until the hidden bit is in place (or the exponent
// limits are reached), then packs exponent/mantissa/guard-round-sticky.
// Optional feature macro: RESULT_NORMALIZER_SUBNORMAL_EN
//   defined   -> gradual underflow (right-shift up to e=1, subnormal pack)
//   undefined -> anything subnormal flushes to zero with underflow_flag
module result_normalizer #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23,
  parameter int ROUNDING_BITS  = 3
) (
  input  logic          clk,
  input  logic          rst,
  result_normalizer_if.slave bus
);
  localparam int W      = MANTISSA_WIDTH + ROUNDING_BITS + 2;
  localparam int EW     = EXPONENT_WIDTH + 2;
  localparam int EMAX_I = (1 << EXPONENT_WIDTH) - 1;

  // Exponent is carried one bit wider than the port so the +1 on a
  // right shift of a maximal input cannot wrap.
  localparam logic signed [EW:0] EMAX  = EMAX_I[EW:0];
  localparam logic signed [EW:0] E_ONE = {{EW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

  state_t                    state, state_nxt;
  logic [W-1:0]              m, m_nxt;
  logic signed [EW:0]        e, e_nxt;
  logic                      load, pack, pack_zero;

  logic [EXPONENT_WIDTH-1:0] exp_q, pk_exp;
  logic [MANTISSA_WIDTH-1:0] mant_q, pk_mant;
  logic [ROUNDING_BITS-1:0]  rb_q, pk_rb;
  logic                      ovf_q, unf_q, pk_ovf, pk_unf;

  assign bus.in_ready          = (state == IDLE);
  assign bus.out_valid         = (state == DONE);
  assign bus.out_exponent      = exp_q;
  assign bus.out_mantissa      = mant_q;
  assign bus.out_rounding_bits = rb_q;
  assign bus.overflow_flag     = ovf_q;
  assign bus.underflow_flag    = unf_q;

  // Pack the current working value (only used when m is nonzero).
  always_comb begin
    pk_exp  = '0;
    pk_mant = '0;
    pk_rb   = '0;
    pk_ovf  = 1'b0;
    pk_unf  = 1'b0;
    if (e >= EMAX) begin
      pk_exp = '1;
      pk_ovf = 1'b1;
    end
`ifdef RESULT_NORMALIZER_SUBNORMAL_EN
    else if (m[W-2]) begin
      pk_exp  = e[EXPONENT_WIDTH-1:0];
      pk_mant = m[W-3:ROUNDING_BITS];
      pk_rb   = m[ROUNDING_BITS-1:0];
    end else begin
      // Denormal: biased exponent field is 0, fraction kept as-is.
      pk_mant = m[W-3:ROUNDING_BITS];
      pk_rb   = m[ROUNDING_BITS-1:0];
      pk_unf  = (|m[ROUNDING_BITS-1:0]) ||
                ((m[W-3:ROUNDING_BITS] == '0) && (m != '0));
    end
`else
    else if ((e < E_ONE) || !m[W-2]) begin
      pk_unf = 1'b1;
    end else begin
      pk_exp  = e[EXPONENT_WIDTH-1:0];
      pk_mant = m[W-3:ROUNDING_BITS];
      pk_rb   = m[ROUNDING_BITS-1:0];
    end
`endif
  end

  // Next state and one normalization action per NORM cycle.
  always_comb begin
    state_nxt = state;
    m_nxt     = m;
    e_nxt     = e;
    load      = 1'b0;
    pack      = 1'b0;
    pack_zero = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          m_nxt     = bus.in_mantissa;
          e_nxt     = {bus.in_exponent[EW-1], bus.in_exponent};
          load      = 1'b1;
          state_nxt = NORM;
        end
      end
      NORM: begin
        if (m == '0) begin
          pack_zero = 1'b1;
          state_nxt = DONE;
        end else if (m[W-1]) begin
          // Right shift; shifted-out bit is folded into sticky.
          m_nxt = {1'b0, m[W-1:2], m[1] | m[0]};
          e_nxt = e + E_ONE;
        end
`ifdef RESULT_NORMALIZER_SUBNORMAL_EN
        else if (e < E_ONE) begin
          m_nxt = {1'b0, m[W-1:2], m[1] | m[0]};
          e_nxt = e + E_ONE;
        end
`endif
        else if (!m[W-2] && (e > E_ONE)) begin
          m_nxt = {m[W-2:0], 1'b0};
          e_nxt = e - E_ONE;
        end else begin
          pack      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working registers and output holding registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      m      <= '0;
      e      <= '0;
      exp_q  <= '0;
      mant_q <= '0;
      rb_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      m     <= m_nxt;
      e     <= e_nxt;
      if (load || pack_zero) begin
        exp_q  <= '0;
        mant_q <= '0;
        rb_q   <= '0;
        ovf_q  <= 1'b0;
        unf_q  <= 1'b0;
      end else if (pack) begin
        exp_q  <= pk_exp;
        mant_q <= pk_mant;
        rb_q   <= pk_rb;
        ovf_q  <= pk_ovf;
        unf_q  <= pk_unf;
      end
    end
  end
endmodule

// File: tb/tb_result_normalizer.sv
// Scoreboard bench for result_normalizer: directed vectors push expected
// results, a negedge monitor pops and compares on each output handshake.
module tb_result_normalizer;
  localparam int EXW = 8;
  localparam int MW  = 23;
  localparam int RB  = 3;
  localparam int W   = MW + RB + 2;
  localparam int EW  = EXW + 2;

  typedef struct {
    logic [EXW-1:0] ex;
    logic [MW-1:0]  mt;
    logic [RB-1:0]  rb;
    logic           ovf;
    logic           unf;
    int             lat;
    int             acc;
    string          nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_normalizer_if #(.EXPONENT_WIDTH(EXW), .MANTISSA_WIDTH(MW), .ROUNDING_BITS(RB)) bus();

  result_normalizer #(.EXPONENT_WIDTH(EXW), .MANTISSA_WIDTH(MW), .ROUNDING_BITS(RB)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   first_vld = 0;
  logic prev_vld  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  // Monitor: compare on every output handshake seen before the accepting edge.
  always @(negedge clk) begin : mon
    exp_t x;
    if (bus.out_valid && !prev_vld) first_vld = cyc;
    prev_vld = bus.out_valid;
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        x = sb.pop_front();
        check({x.nm, "_exp"},  32'(bus.out_exponent),      32'(x.ex));
        check({x.nm, "_mant"}, 32'(bus.out_mantissa),      32'(x.mt));
        check({x.nm, "_rb"},   32'(bus.out_rounding_bits), 32'(x.rb));
        check({x.nm, "_ovf"},  32'(bus.overflow_flag),     32'(x.ovf));
        check({x.nm, "_unf"},  32'(bus.underflow_flag),    32'(x.unf));
        check({x.nm, "_lat"},  32'(first_vld - x.acc),     32'(x.lat));
      end
    end
  end

  task automatic send(input string nm, input logic [W-1:0] mi, input logic [EW-1:0] ei,
                      input logic [EXW-1:0] xe, input logic [MW-1:0] xm, input logic [RB-1:0] xr,
                      input logic xo, input logic xu, input int lat, input bit push);
    exp_t x;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check({nm, "_in_ready_timeout"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid    = 1'b1;
    bus.in_mantissa = mi;
    bus.in_exponent = ei;
    if (push) begin
      x.ex = xe; x.mt = xm; x.rb = xr; x.ovf = xo; x.unf = xu;
      x.lat = lat; x.acc = cyc; x.nm = nm;
      sb.push_back(x);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid    = 1'b0;
    bus.in_mantissa = '0;
    bus.in_exponent = '0;
    bus.out_ready   = 1'b1;
    rst             = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_in_ready",  32'(bus.in_ready),          32'd1);
    check("rst_out_valid", 32'(bus.out_valid),         32'd0);
    check("rst_exp",       32'(bus.out_exponent),      32'd0);
    check("rst_mant",      32'(bus.out_mantissa),      32'd0);
    check("rst_rb",        32'(bus.out_rounding_bits), 32'd0);
    check("rst_flags",     32'({bus.overflow_flag, bus.underflow_flag}), 32'd0);
    rst = 1'b0;

    send("already_norm", 28'h4000000, 10'd127, 8'd127, 23'h0, 3'b000, 1'b0, 1'b0, 2, 1'b1);
    send("carry_rshift", 28'h8000001, 10'd127, 8'd128, 23'h0, 3'b001, 1'b0, 1'b0, 3, 1'b1);
    send("lshift_23",    28'h0000008, 10'd127, 8'd104, 23'h0, 3'b000, 1'b0, 1'b0, 25, 1'b1);
    send("ovf_carry",    28'h8000000, 10'd254, 8'hFF,  23'h0, 3'b000, 1'b1, 1'b0, 3, 1'b1);
    send("ovf_direct",   28'h4000000, 10'd300, 8'hFF,  23'h0, 3'b000, 1'b1, 1'b0, 2, 1'b1);
    send("zero_in",      28'h0000000, 10'd50,  8'd0,   23'h0, 3'b000, 1'b0, 1'b0, 2, 1'b1);
    send("fraction",     28'h4ABCDE5, 10'd100, 8'd100, 23'h1579BC, 3'b101, 1'b0, 1'b0, 2, 1'b1);
`ifdef RESULT_NORMALIZER_SUBNORMAL_EN
    send("subn_lshift",  28'h0000008, 10'd10,  8'd0, 23'h000200, 3'b000, 1'b0, 1'b0, 11, 1'b1);
    send("subn_exp0",    28'h4000000, 10'd0,   8'd0, 23'h400000, 3'b000, 1'b0, 1'b0, 3, 1'b1);
    send("subn_sticky",  28'h4000001, 10'h3FE, 8'd0, 23'h100000, 3'b001, 1'b0, 1'b1, 5, 1'b1);
`else
    send("flush_lshift", 28'h0000008, 10'd10,  8'd0, 23'h0, 3'b000, 1'b0, 1'b1, 11, 1'b1);
    send("flush_exp0",   28'h4000000, 10'd0,   8'd0, 23'h0, 3'b000, 1'b0, 1'b1, 2, 1'b1);
    send("flush_neg",    28'h4000001, 10'h3FE, 8'd0, 23'h0, 3'b000, 1'b0, 1'b1, 2, 1'b1);
`endif
    drain();

    // Backpressure: output must hold while out_ready is low.
    @(posedge clk); #1 bus.out_ready = 1'b0;
    send("stall", 28'h4ABCDE5, 10'd100, 8'd100, 23'h1579BC, 3'b101, 1'b0, 1'b0, 2, 1'b1);
    begin
      int n;
      n = 0;
      while (!bus.out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (n >= 50) check("stall_valid_timeout", 32'(bus.out_valid), 32'd1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(bus.out_valid),         32'd1);
      check("stall_in_ready",  32'(bus.in_ready),          32'd0);
      check("stall_exp",       32'(bus.out_exponent),      32'd100);
      check("stall_mant",      32'(bus.out_mantissa),      32'h1579BC);
      check("stall_rb",        32'(bus.out_rounding_bits), 32'd5);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("drop_out_valid", 32'(bus.out_valid), 32'd0);
    check("drop_in_ready",  32'(bus.in_ready),  32'd1);
    drain();

    // Reset in the middle of a long left-shift sequence drops the item.
    send("rst_drop", 28'h0000008, 10'd127, 8'd0, 23'h0, 3'b000, 1'b0, 1'b0, 0, 1'b0);
    repeat (4) @(negedge clk);
    check("mid_norm_in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    send("after_rst", 28'h4000000, 10'd127, 8'd127, 23'h0, 3'b000, 1'b0, 1'b0, 2, 1'b1);
    drain();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
